// File: rtl/xnor_prbs_tx.sv
// XNOR-feedback LFSR bit transmitter with programmable bursts and a valid/ready output.
// Optional single-bit error injection is compiled in with `define ERR_INJ_EN.
module xnor_prbs_tx #(
  parameter int               WIDTH = 7,
  parameter int               TAP_A = 6,
  parameter int               TAP_B = 5,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ERR_INJ_EN
  input  logic             err_inj,
`endif
  input  logic             start,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] burst_len,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             fire;
  logic             fb;
  logic [WIDTH-1:0] seed_san;

  assign fire = (state_q == RUN) && tx_ready;
  assign fb   = ~(lfsr_q[TAP_A] ^ lfsr_q[TAP_B]);

  // All-ones is the XNOR lockup state; never let it into the register.
  assign seed_san = (&seed_in) ? '0 : seed_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (burst_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (fire && (cnt_q == CNT_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (seed_ld) begin
          lfsr_d = seed_san;
        end
        if (start && (burst_len != '0)) begin
          cnt_d = burst_len;
        end
      end
      RUN: begin
        if (fire) begin
          lfsr_d = {lfsr_q[WIDTH-2:0], fb};
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

`ifdef ERR_INJ_EN
  // Flag arms from any state and is consumed only by an actual transfer.
  assign err_d = (err_q & ~fire) | err_inj;
`else
  assign err_d = 1'b0;
`endif

  always_comb begin
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    tx_bit   = 1'b0;
    unique case (state_q)
      RUN: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = lfsr_q[WIDTH-1] ^ err_q;
      end
      DONE:    done = 1'b1;
      default: tx_bit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_xnor_prbs_tx.sv
// Scoreboard bench for xnor_prbs_tx: stimulus pushes expected bits,
// a negedge monitor pops and compares on every transfer and done pulse.
module tb_xnor_prbs_tx;

  localparam int W  = 7;
  localparam int TA = 6;
  localparam int TB = 5;
  localparam int DONE_TOK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        seed_ld = 1'b0;
  logic [6:0]  seed_in = '0;
  logic [15:0] burst_len = '0;
  logic        tx_ready = 1'b0;
  logic        tx_bit, tx_valid, busy, done;
`ifdef ERR_INJ_EN
  logic        err_inj = 1'b0;
`endif

  int exp_q[$];
  int win[$];
  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int ready_mode = 0;
  int pc = 0;

  xnor_prbs_tx dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ERR_INJ_EN
    .err_inj   (err_inj),
`endif
    .start     (start),
    .seed_ld   (seed_ld),
    .seed_in   (seed_in),
    .burst_len (burst_len),
    .tx_bit    (tx_bit),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output stream b obeys b[n+W] = ~(b[n+W-1-TA] ^ b[n+W-1-TB]);
  // win holds the next W stream bits, oldest first.
  function automatic void load_seed(input logic [6:0] s);
    logic [6:0] v;
    v = (s == 7'h7F) ? 7'h00 : s;
    win.delete();
    for (int i = W - 1; i >= 0; i--) win.push_back(int'(v[i]));
  endfunction

  function automatic int next_bit();
    int b, nb;
    b  = win[0];
    nb = (win[W-1-TA] ^ win[W-1-TB]) ? 0 : 1;
    void'(win.pop_front());
    win.push_back(nb);
    return b;
  endfunction

  // Sink back-pressure generator.
  initial forever begin
    @(posedge clk);
    #1;
    pc++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (pc % 3 == 0);
    endcase
  end

  // Monitor: pops one expectation per transfer or done pulse.
  initial begin
    int   e;
    logic stall_v;
    logic stall_b;
    stall_v = 1'b0;
    stall_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v) check("stall_hold", tx_bit, stall_b);
        stall_v = tx_valid && !tx_ready;
        stall_b = tx_bit;
        if (tx_valid && tx_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_bit: got bit %0d expected none", tx_bit);
          end else begin
            e = exp_q.pop_front();
            check("tx_bit", tx_bit, e);
          end
        end
        if (done) begin
          check("done_no_valid", tx_valid, 0);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            e = exp_q.pop_front();
            check("done", DONE_TOK, e);
          end
        end
      end
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic issue(input logic ld, input logic [6:0] s,
                       input int len, input logic inj);
    int b;
    @(posedge clk);
    #1;
`ifdef ERR_INJ_EN
    if (inj) begin
      err_inj = 1'b1;
      @(posedge clk);
      #1;
      err_inj = 1'b0;
    end
`endif
    if (ld) load_seed(s);
    for (int i = 0; i < len; i++) begin
      b = next_bit();
      if (i == 0 && inj) b = b ^ 1;
      exp_q.push_back(b);
    end
    exp_q.push_back(DONE_TOK);
    start     = 1'b1;
    seed_ld   = ld;
    seed_in   = s;
    burst_len = 16'(len);
    @(posedge clk);
    #1;
    start   = 1'b0;
    seed_ld = 1'b0;
    check("valid_latency", tx_valid, int'(len != 0));
    check("done_latency", done, int'(len == 0));
  endtask

  task automatic burst(input logic ld, input logic [6:0] s,
                       input int len, input logic inj);
    bit idle;
    issue(ld, s, len, inj);
    idle = 1'b0;
    for (int n = 0; n < len * 5 + 20; n++) begin
      @(negedge clk);
      if (!busy && !done) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      fails++;
      $display("FAIL burst_timeout: got busy %0d expected idle", busy);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "burst did not complete");
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid_burst();
    int x0;
    bit hit;
    issue(1'b1, 7'h35, 200, 1'b0);
    x0  = xfers;
    hit = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (xfers - x0 >= 50) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL reset_wait: got %0d transfers expected 50", xfers - x0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", tx_valid, 0);
    check("rst_mid_bit", tx_bit, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    exp_q.delete();
    load_seed(7'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_bit", tx_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    load_seed(7'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    ready_mode = 0;
    burst(1'b1, 7'h00, 8, 1'b0);
    ready_mode = 2;
    burst(1'b1, 7'h00, 8, 1'b0);
    ready_mode = 0;
    burst(1'b1, 7'h7F, 3, 1'b0);
    burst(1'b0, 7'h00, 0, 1'b0);
    burst(1'b0, 7'h00, 20, 1'b0);

    ready_mode = 1;
    reset_mid_burst();
    ready_mode = 0;
    burst(1'b0, 7'h00, 140, 1'b0);

    for (int k = 0; k < 12; k++) begin
      ready_mode = $urandom_range(0, 2);
      burst(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 127)),
            $urandom_range(0, 40), 1'b0);
    end

`ifdef ERR_INJ_EN
    ready_mode = 2;
    burst(1'b1, 7'h00, 8, 1'b1);
    burst(1'b0, 7'h00, 8, 1'b0);
`endif

    repeat (3) @(posedge clk);
    finish_run();
  end

endmodule
